// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped LED sequencer.
// Combinational definitions only; no latency, no flow control.
package mmio_pkg;

  localparam logic [11:0] LED_ADDR    = 12'd6;
  localparam logic [11:0] STATUS_ADDR = 12'd7;

  localparam int CMD_QUEUED_BIT = 31;
  localparam int CMD_LEVEL_BIT  = 0;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } seq_state_t;

  // Down-counter width able to hold max(a,b)-1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; data visible at dout the cycle after the push.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_led_sequencer.sv
// dmem-snooping LED peripheral: direct levels plus a FIFO of timed flashes.
// Writes land on the next edge; queued flashes start one cycle after the push, full queue drops and flags overflow.
module mmio_led_sequencer
  import mmio_pkg::*;
#(
  parameter int          N_LEDS       = 4,
  parameter int          QUEUE_DEPTH  = 4,
  parameter int          FLASH_CYCLES = 25000000,
  parameter int          GAP_CYCLES   = 12500000,
  parameter logic [11:0] ADDR_LED     = LED_ADDR,
  parameter logic [11:0] ADDR_STATUS  = STATUS_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [11:0]       address,
  input  logic [31:0]       data_in,
  output logic              rd_hit,
  output logic [31:0]       rd_data,
  output logic [N_LEDS-1:0] leds,
  output logic              busy
);

  localparam int CH_W  = $clog2(N_LEDS);
  localparam int CNT_W = cnt_width(FLASH_CYCLES, GAP_CYCLES);
  localparam int QC_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CH_W-1:0]   ch;
  logic [31:0]       ch_ext;
  logic              ch_ok;
  logic [N_LEDS-1:0] ch_mask;
  logic              cmd_wr;
  logic              stat_wr;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CH_W-1:0]   fifo_dout;
  logic [QC_W-1:0]   fifo_count;
  logic [N_LEDS-1:0] level;
  logic [N_LEDS-1:0] flash_mask;
  logic              overflow;
  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              unused_data;

  // Out-of-range channels are discarded before they touch levels or the queue.
  assign ch          = data_in[CH_W:1];
  assign ch_ext      = 32'(ch);
  assign ch_ok       = (ch_ext < 32'(N_LEDS));
  assign ch_mask     = N_LEDS'(1) << ch;
  assign cmd_wr      = wren && (address == ADDR_LED) && ch_ok;
  assign stat_wr     = wren && (address == ADDR_STATUS);
  assign push        = cmd_wr && data_in[CMD_QUEUED_BIT];
  assign pop         = (state == S_IDLE) && !fifo_empty;
  assign unused_data = &{1'b0, data_in[30:CH_W+1]};

  sync_fifo #(
    .WIDTH (CH_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ch),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (cmd_wr && !data_in[CMD_QUEUED_BIT]) begin
        level <= data_in[CMD_LEVEL_BIT] ? (level | ch_mask) : (level & ~ch_mask);
      end
      // Clear beats a same-cycle drop so software never loses its acknowledge.
      if (stat_wr) begin
        overflow <= 1'b0;
      end else if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      flash_mask <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            flash_mask <= N_LEDS'(1) << fifo_dout;
            cnt        <= FLASH_LOAD;
            state      <= S_ON;
          end
        end
        S_ON: begin
          if (cnt == '0) begin
            flash_mask <= '0;
            cnt        <= GAP_LOAD;
            state      <= S_GAP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          flash_mask <= '0;
          cnt        <= '0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign leds   = level | flash_mask;
  assign busy   = (state != S_IDLE) || !fifo_empty;
  assign rd_hit = (address == ADDR_STATUS);

  always_comb begin
    rd_data                               = '0;
    rd_data[STAT_BUSY_BIT]                = busy;
    rd_data[STAT_OVF_BIT]                 = overflow;
    rd_data[STAT_COUNT_LSB +: QC_W]       = fifo_count;
  end

endmodule

// File: tb/tb_mmio_led_sequencer.sv
// Directed bench for mmio_led_sequencer: level table, timed flashes, overflow, reset and range checks.
module tb_mmio_led_sequencer;

  logic        clock;
  logic        reset;
  logic        wren;
  logic [11:0] address;
  logic [31:0] data_in;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic [3:0]  leds;
  logic        busy;

  logic        wren5;
  logic [11:0] address5;
  logic [31:0] data5;
  logic        rd_hit5;
  logic [31:0] rd_data5;
  logic [4:0]  leds5;
  logic        busy5;

  int tests;
  int fails;

  mmio_led_sequencer #(
    .N_LEDS(4), .QUEUE_DEPTH(4), .FLASH_CYCLES(4), .GAP_CYCLES(2),
    .ADDR_LED(12'd6), .ADDR_STATUS(12'd7)
  ) dut (
    .clock(clock), .reset(reset), .wren(wren), .address(address), .data_in(data_in),
    .rd_hit(rd_hit), .rd_data(rd_data), .leds(leds), .busy(busy)
  );

  // Five channels so the 3-bit channel field can name an absent LED.
  mmio_led_sequencer #(
    .N_LEDS(5), .QUEUE_DEPTH(4), .FLASH_CYCLES(4), .GAP_CYCLES(2),
    .ADDR_LED(12'd6), .ADDR_STATUS(12'd7)
  ) dut5 (
    .clock(clock), .reset(reset), .wren(wren5), .address(address5), .data_in(data5),
    .rd_hit(rd_hit5), .rd_data(rd_data5), .leds(leds5), .busy(busy5)
  );

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  exp_leds;
    logic        exp_busy;
    logic [31:0] exp_stat;
  } vec_t;

  vec_t vecs [11];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic w, input logic [11:0] a, input logic [31:0] d);
    wren    = w;
    address = a;
    data_in = d;
    step();
    wren    = 1'b0;
    address = 12'd0;
    data_in = 32'd0;
  endtask

  task automatic wr5(input logic [11:0] a, input logic [31:0] d);
    wren5    = 1'b1;
    address5 = a;
    data5    = d;
    step();
    wren5    = 1'b0;
    address5 = 12'd0;
    data5    = 32'd0;
  endtask

  // Flash windows when ch0..ch(n-1) are queued from t=0: ON at t in [1+7j, 4+7j].
  function automatic logic [3:0] exp_flash(input int t, input int n);
    logic [3:0] r;
    r = 4'b0000;
    for (int j = 0; j < n; j++) begin
      if (t >= 1 + 7 * j && t <= 4 + 7 * j) r = 4'(1 << j);
    end
    return r;
  endfunction

  initial begin : main
    int n;
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    wren     = 1'b0;
    address  = 12'd0;
    data_in  = 32'd0;
    wren5    = 1'b0;
    address5 = 12'd0;
    data5    = 32'd0;

    vecs[0]  = '{1'b1, 12'd6, 32'h0000_0005, 4'b0100, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 12'd6, 32'h0000_0004, 4'b0000, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 12'd6, 32'h0000_0001, 4'b0001, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 12'd6, 32'h0000_0007, 4'b1001, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 12'd6, 32'h0000_0003, 4'b1011, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 12'd5, 32'h0000_0005, 4'b1011, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 12'd6, 32'h0000_0005, 4'b1011, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 12'd7, 32'h0000_0005, 4'b1011, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 12'd6, 32'h0000_0000, 4'b1010, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 12'd6, 32'h0000_0006, 4'b0010, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 12'd6, 32'h0000_0002, 4'b0000, 1'b0, 32'h0};

    step();
    step();
    reset = 1'b0;
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_stat", rd_data, 32'h0);
    chk("rst_leds5", 32'(leds5), 32'h0);
    chk("rst_stat5", rd_data5, 32'h0);
    chk("rd_hit_addr0", 32'(rd_hit), 32'h0);
    address = 12'd7;
    #1;
    chk("rd_hit_addr7", 32'(rd_hit), 32'h1);
    address = 12'd6;
    #1;
    chk("rd_hit_addr6", 32'(rd_hit), 32'h0);
    address = 12'd0;

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].w, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_stat", i), rd_data, vecs[i].exp_stat);
    end

    // Single queued flash on ch1.
    apply(1'b1, 12'd6, 32'h8000_0002);
    chk("qa_leds_t0", 32'(leds), 32'h0);
    chk("qa_busy_t0", 32'(busy), 32'h1);
    chk("qa_stat_t0", rd_data, 32'h0000_0101);
    for (int t = 1; t <= 10; t++) begin
      step();
      chk($sformatf("qa_leds_t%0d", t), 32'(leds), (t <= 4) ? 32'h2 : 32'h0);
      chk($sformatf("qa_busy_t%0d", t), 32'(busy), (t <= 6) ? 32'h1 : 32'h0);
    end
    chk("qa_stat_end", rd_data, 32'h0);

    // Four channels queued back to back play in order with a 7-cycle period.
    for (int t = 0; t < 4; t++) begin
      apply(1'b1, 12'd6, 32'h8000_0000 | 32'(t << 1));
      chk($sformatf("qb_leds_t%0d", t), 32'(leds), 32'(exp_flash(t, 4)));
    end
    chk("qb_stat_after_push", rd_data, 32'h0000_0301);
    for (int t = 4; t <= 30; t++) begin
      step();
      chk($sformatf("qb_leds_t%0d", t), 32'(leds), 32'(exp_flash(t, 4)));
      chk($sformatf("qb_busy_t%0d", t), 32'(busy), (t < 28) ? 32'h1 : 32'h0);
    end
    chk("qb_stat_end", rd_data, 32'h0);

    // Six pushes: one pops, four held, the sixth drops and sets overflow.
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 12'd6, 32'h8000_0000 | 32'((i % 4) << 1));
    end
    chk("qc_stat_overflow", rd_data, 32'h0000_0403);
    apply(1'b1, 12'd7, 32'h0);
    chk("qc_stat_cleared", rd_data, 32'h0000_0401);
    chk("qc_leds_gap", 32'(leds), 32'h0);
    step();
    chk("qc_leds_idle", 32'(leds), 32'h0);
    step();
    chk("qc_leds_next", 32'(leds), 32'h2);
    chk("qc_stat_next", rd_data, 32'h0000_0301);
    n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    chk("qc_drain_busy", 32'(busy), 32'h0);
    chk("qc_stat_end", rd_data, 32'h0);

    // Reset mid-flash clears levels, queue and sequencer, and beats a same-cycle write.
    apply(1'b1, 12'd6, 32'h0000_0001);
    apply(1'b1, 12'd6, 32'h8000_0004);
    step();
    step();
    chk("qd_leds_on", 32'(leds), 32'h5);
    reset   = 1'b1;
    wren    = 1'b1;
    address = 12'd6;
    data_in = 32'h0000_0007;
    step();
    reset   = 1'b0;
    wren    = 1'b0;
    address = 12'd0;
    data_in = 32'd0;
    chk("qd_leds_rst", 32'(leds), 32'h0);
    chk("qd_busy_rst", 32'(busy), 32'h0);
    chk("qd_stat_rst", rd_data, 32'h0);
    for (int t = 1; t <= 10; t++) begin
      step();
      chk($sformatf("qd_leds_after_t%0d", t), 32'(leds), 32'h0);
      chk($sformatf("qd_busy_after_t%0d", t), 32'(busy), 32'h0);
    end

    // Channel 5 does not exist on the five-LED instance; channel 4 does.
    wr5(12'd6, 32'h8000_000A);
    chk("qe_stat_bad_q", rd_data5, 32'h0);
    chk("qe_busy_bad_q", 32'(busy5), 32'h0);
    chk("qe_leds_bad_q", 32'(leds5), 32'h0);
    wr5(12'd6, 32'h0000_000B);
    chk("qe_leds_bad_lvl", 32'(leds5), 32'h0);
    wr5(12'd6, 32'h0000_0009);
    chk("qe_leds_ch4_lvl", 32'(leds5), 32'h10);
    wr5(12'd6, 32'h8000_0008);
    chk("qe_stat_ch4_q", rd_data5, 32'h0000_0101);
    chk("qe_busy_ch4_q", 32'(busy5), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
